dds_sin_gen: RTL and testbench

DDS_SIN_GEN -- requirements
Module: dds_sin_gen

---
 rtl/dds_sin_gen.sv | 107 ++++++++++
 tb/tb_dds_sin_gen.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dds_sin_gen.sv
// Pipelined DDS sine generator: phase accumulator, quarter-wave ROM, optional amplitude scaling.
// Define DDS_SIN_GEN_AMP_EN to build the amplitude multiplier; otherwise the raw LUT sample is output.
module dds_sin_gen #(
  parameter int OUT_W   = 16,
  parameter int PHASE_W = 24,
  parameter int LUT_AW  = 8,
  parameter int AMP_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               phase_clr,
  input  logic [PHASE_W-1:0] ftw,
  input  logic               ftw_load,
  input  logic [AMP_W-1:0]   amp,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [OUT_W-1:0]   out,
  output logic               out_wrap
);

  localparam int  LutN   = 2 ** LUT_AW;
  localparam real HalfPi = 1.5707963267948966;
  localparam real LutAmp = real'((2 ** (OUT_W - 1)) - 1);

  // Quarter-wave ROM sampled at bin centres so mirrored halves stay symmetric.
  logic [OUT_W-1:0] lut_rom [LutN];
  for (genvar k = 0; k < LutN; k++) begin : g_lut
    localparam int Val = $rtoi(LutAmp * $sin(HalfPi * (real'(k) + 0.5) / real'(LutN)) + 0.5);
    assign lut_rom[k] = OUT_W'(Val);
  end

  logic               adv, inject;
  logic [PHASE_W-1:0] acc_q, tw_q;
  logic               wrap_pend_q;
  logic [PHASE_W:0]   acc_sum;
  logic [1:0]         quad;
  logic [LUT_AW-1:0]  idx;

  logic                    s1_v_q, s1_neg_q, s1_wrap_q;
  logic [LUT_AW-1:0]       s1_idx_q;
  logic                    s2_v_q, s2_wrap_q;
  logic signed [OUT_W-1:0] s2_val_q;
  logic signed [OUT_W-1:0] lut_mag, s3_d;

  assign adv     = !out_valid || out_ready;
  assign inject  = adv && en;
  assign acc_sum = {1'b0, acc_q} + {1'b0, tw_q};
  assign quad    = acc_q[PHASE_W-1 -: 2];
  assign idx     = acc_q[PHASE_W-3 -: LUT_AW];
  assign lut_mag = $signed(lut_rom[s1_idx_q]);

`ifdef DDS_SIN_GEN_AMP_EN
  logic signed [OUT_W+AMP_W:0] prod;
  assign prod = s2_val_q * $signed({1'b0, amp});
  assign s3_d = OUT_W'(prod >>> AMP_W);
`else
  logic unused_amp;
  assign unused_amp = ^amp;
  assign s3_d       = s2_val_q;
`endif

  // wrap_pend_q tags the next injected sample as the start of a period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q       <= '0;
      tw_q        <= '0;
      wrap_pend_q <= 1'b1;
    end else begin
      if (ftw_load) tw_q <= ftw;
      if (phase_clr) begin
        acc_q       <= '0;
        wrap_pend_q <= 1'b1;
      end else if (inject) begin
        acc_q       <= acc_sum[PHASE_W-1:0];
        wrap_pend_q <= acc_sum[PHASE_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v_q    <= 1'b0;
      s1_neg_q  <= 1'b0;
      s1_wrap_q <= 1'b0;
      s1_idx_q  <= '0;
      s2_v_q    <= 1'b0;
      s2_wrap_q <= 1'b0;
      s2_val_q  <= '0;
      out_valid <= 1'b0;
      out_wrap  <= 1'b0;
      out       <= '0;
    end else if (adv) begin
      s1_v_q    <= en;
      s1_neg_q  <= quad[1];
      s1_wrap_q <= wrap_pend_q;
      s1_idx_q  <= quad[0] ? ~idx : idx;
      s2_v_q    <= s1_v_q;
      s2_wrap_q <= s1_v_q && s1_wrap_q;
      s2_val_q  <= s1_neg_q ? -lut_mag : lut_mag;
      out_valid <= s2_v_q;
      out_wrap  <= s2_v_q && s2_wrap_q;
      out       <= s3_d;
    end
  end

endmodule

// File: tb/tb_dds_sin_gen.sv
// Scoreboard bench for dds_sin_gen: directed scenarios plus randomized handshake/phase traffic.
module tb_dds_sin_gen;

  localparam real PI = 3.141592653589793;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0, phase_clr = 1'b0, ftw_load = 1'b0, out_ready = 1'b0;
  logic [23:0] ftw = '0;
  logic [15:0] amp = 16'd32768;
  logic        out_valid, out_wrap;
  logic [15:0] out;

  dds_sin_gen #(.OUT_W(16), .PHASE_W(24), .LUT_AW(8), .AMP_W(16)) dut (
    .clk(clk), .rst(rst), .en(en), .phase_clr(phase_clr), .ftw(ftw), .ftw_load(ftw_load),
    .amp(amp), .out_ready(out_ready), .out_valid(out_valid), .out(out), .out_wrap(out_wrap)
  );

  always #5 clk = ~clk;

  typedef struct {int val; bit wrap;} exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_pass = 0;
  int n_acc = 0;

  task automatic check(input string name, input longint act, input longint expv);
    n_checks++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
  endtask

  // Reference: sine of the phase via quarter-wave mirroring, rounded, optionally scaled.
  function automatic int exp_sample(input int unsigned p);
    int unsigned q, k;
    int mag, v;
    q = p >> 22;
    k = (p >> 14) & 255;
    if (q == 1 || q == 3) k = 255 - k;
    mag = $rtoi(32767.0 * $sin(PI / 2.0 * (real'(k) + 0.5) / 256.0) + 0.5);
    v = (q >= 2) ? -mag : mag;
`ifdef DDS_SIN_GEN_AMP_EN
    v = int'((longint'(v) * longint'(amp)) >>> 16);
`endif
    return v;
  endfunction

  // Reference model: accumulator, tuning word and period marker.
  int unsigned m_acc = 0, m_tw = 0;
  bit          m_wrap = 1'b1;
  bit          m_adv;
  longint      m_sum;
  exp_t        m_e;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_acc = 0;
      m_tw = 0;
      m_wrap = 1'b1;
    end else begin
      m_adv = !out_valid || out_ready;
      if (m_adv && en) begin
        m_e.val = exp_sample(m_acc);
        m_e.wrap = m_wrap;
        exp_q.push_back(m_e);
      end
      if (phase_clr) begin
        m_acc = 0;
        m_wrap = 1'b1;
      end else if (m_adv && en) begin
        m_sum = longint'(m_acc) + longint'(m_tw);
        m_wrap = (m_sum >= 64'd16777216);
        m_acc = int'(m_sum % 64'd16777216);
      end
      if (ftw_load) m_tw = ftw;
    end
  end

  // Monitor: pop on every accepted sample; check outputs hold while stalled.
  bit          prev_stall = 1'b0;
  logic [15:0] prev_out;
  logic        prev_wrap;
  exp_t        mon_e;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_hold_out", out, prev_out);
        check("stall_hold_wrap", out_wrap, prev_wrap);
      end
      if (out_valid && out_ready) begin
        n_acc++;
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_sample: got %0d with no sample expected at %0t",
                   $signed(out), $time);
        end else begin
          mon_e = exp_q.pop_front();
          check("sample", $signed(out), mon_e.val);
          check("sample_wrap", out_wrap, mon_e.wrap);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_out = out;
      prev_wrap = out_wrap;
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load_ftw(input logic [23:0] w);
    ftw = w;
    ftw_load = 1'b1;
    step();
    ftw_load = 1'b0;
  endtask

  task automatic drain();
    int cyc;
    en = 1'b0;
    out_ready = 1'b1;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 30) begin
      step();
      cyc++;
    end
    step(3);
    check("drain_empty", exp_q.size(), 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  int cyc;
  int n0;
  int first_val;

  initial begin
`ifdef DDS_SIN_GEN_AMP_EN
    first_val = 50;
`else
    first_val = 101;
`endif
    #2 rst = 1'b1;
    step(2);
    check("reset_valid", out_valid, 0);
    check("reset_out", out, 0);
    check("reset_wrap", out_wrap, 0);
    rst = 1'b0;
    step();

    // Quarter-period tuning word, free running; first sample latency and value.
    load_ftw(24'h400000);
    en = 1'b1;
    out_ready = 1'b1;
    cyc = 0;
    while (!out_valid && cyc < 10) begin
      step();
      cyc++;
    end
    check("first_latency", cyc, 3);
    check("first_value", $signed(out), first_val);
    check("first_wrap", out_wrap, 1);
    step(10);

    // Downstream stall for 5 cycles.
    out_ready = 1'b0;
    step(5);
    out_ready = 1'b1;
    step(8);
    drain();

    // Half-period word with a phase clear mid-stream.
    load_ftw(24'h800000);
    en = 1'b1;
    step(5);
    phase_clr = 1'b1;
    step();
    phase_clr = 1'b0;
    step(6);
    drain();

    // Reset with a full pipeline takes effect without a clock edge.
    load_ftw(24'h400000);
    en = 1'b1;
    step(6);
    rst = 1'b1;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_out", out, 0);
    step(2);
    rst = 1'b0;
    en = 1'b0;
    load_ftw(24'h400000);
    en = 1'b1;
    step(8);
    drain();

    // en pulse pattern 1,0,1 delivers exactly two samples.
    n0 = n_acc;
    en = 1'b1;
    step();
    en = 1'b0;
    step();
    en = 1'b1;
    step();
    drain();
    check("en_toggle_count", n_acc - n0, 2);

    // Randomized traffic with fixed amplitude.
    amp = 16'($urandom_range(0, 65535));
    for (int i = 0; i < 600; i++) begin
      en = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      phase_clr = ($urandom_range(0, 31) == 0);
      ftw_load = ($urandom_range(0, 15) == 0);
      ftw = 24'($urandom);
      step();
    end
    phase_clr = 1'b0;
    ftw_load = 1'b0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
